mux_arbiter8: RTL and testbench

MUX_ARBITER8 -- requirements
Module: mux_arbiter8

---
 rtl/mux_arbiter8_if.sv | 31 +++
 rtl/mux_arbiter8.sv | 141 ++++++++++++++
 tb/tb_mux_arbiter8.sv | 118 +++++++++++
 3 files changed

// File: rtl/mux_arbiter8_if.sv
// Requester-side bus of the 8-way round-robin mux arbiter: requests, data, grant, select, output.
// Latency: none (signal bundle only).
// Backpressure: ready is driven by the downstream consumer of F; master drives, slave (arbiter) responds.
interface mux_arbiter8_if #(
    parameter int N = 1
);
    logic [7:0]   req;
    logic [N-1:0] I00;
    logic [N-1:0] I01;
    logic [N-1:0] I02;
    logic [N-1:0] I03;
    logic [N-1:0] I04;
    logic [N-1:0] I05;
    logic [N-1:0] I06;
    logic [N-1:0] I07;
    logic         ready;
    logic [7:0]   grant;
    logic [2:0]   sel;
    logic         valid;
    logic [N-1:0] F;

    modport master (
        output req, I00, I01, I02, I03, I04, I05, I06, I07, ready,
        input  grant, sel, valid, F
    );

    modport slave (
        input  req, I00, I01, I02, I03, I04, I05, I06, I07, ready,
        output grant, sel, valid, F
    );
endinterface

// File: rtl/mux_arbiter8.sv
// 8-way round-robin arbiter with 8:1 data mux; optional per-grant transfer limit via ARB_HOLD_LIMIT_EN.
// Latency: grant/sel/valid registered one cycle after request seen in IDLE; F combinational from sel.
// Backpressure: ready=0 holds owner, grant and data; release always costs one IDLE cycle.
module mux_arbiter8 #(
    parameter int N        = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic            clock,
    input  logic            reset,
    mux_arbiter8_if.slave   bus
);
    typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

    state_t       r_state;
    logic [2:0]   r_sel;
    logic [2:0]   r_last;
    logic [7:0]   r_grant;
    logic         r_valid;

    state_t       w_state_nxt;
    logic [2:0]   w_sel_nxt;
    logic [2:0]   w_last_nxt;
    logic [7:0]   w_grant_nxt;
    logic         w_valid_nxt;
    logic [2:0]   w_winner;
    logic         w_found;
    logic [N-1:0] w_f;

    // Legal MAX_HOLD is 1..15; an out-of-range value shows up as this named scope in the hierarchy.
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_out_of_range
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
    logic [3:0] r_hold;
    logic [3:0] w_hold_nxt;
    logic       w_xfer;
    assign w_xfer = r_valid & bus.ready;
`endif

    // Round-robin pick: first requesting index after the previous owner, wrapping mod 8.
    always_comb begin
        w_winner = r_last;
        w_found  = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (!w_found && bus.req[3'(r_last + 3'(i))]) begin
                w_winner = 3'(r_last + 3'(i));
                w_found  = 1'b1;
            end
        end
    end

    // State register: reset wins over every event, including a transfer in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_last  <= 3'd7;
            r_grant <= 8'h00;
            r_valid <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            r_hold  <= 4'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
`ifdef ARB_HOLD_LIMIT_EN
            r_hold  <= w_hold_nxt;
`endif
        end
    end

    // Next state: grant from IDLE, keep ownership while the owner requests, release to IDLE otherwise.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
`ifdef ARB_HOLD_LIMIT_EN
        w_hold_nxt  = r_hold;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_OWN;
                    w_sel_nxt   = w_winner;
`ifdef ARB_HOLD_LIMIT_EN
                    w_hold_nxt  = 4'd0;
`endif
                end
            end
            ST_OWN: begin
                if (!bus.req[r_sel]) begin
                    // Owner dropped its request: leave whether or not a transfer happened.
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_sel;
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (w_xfer) begin
                    if (r_hold == HOLD_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = r_sel;
                    end else begin
                        w_hold_nxt = r_hold + 4'd1;
                    end
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs for the next cycle, derived from the next state so grant/valid leave flops directly.
    always_comb begin
        w_valid_nxt = (w_state_nxt == ST_OWN);
        w_grant_nxt = w_valid_nxt ? (8'h01 << w_sel_nxt) : 8'h00;
    end

    // Unregistered 8:1 data select driven by the owner index.
    always_comb begin
        case (r_sel)
            3'd0:    w_f = bus.I00;
            3'd1:    w_f = bus.I01;
            3'd2:    w_f = bus.I02;
            3'd3:    w_f = bus.I03;
            3'd4:    w_f = bus.I04;
            3'd5:    w_f = bus.I05;
            3'd6:    w_f = bus.I06;
            default: w_f = bus.I07;
        endcase
    end

    assign bus.grant = r_grant;
    assign bus.sel   = r_sel;
    assign bus.valid = r_valid;
    assign bus.F     = w_f;
endmodule

// File: tb/tb_mux_arbiter8.sv
// Directed bench for mux_arbiter8: each step drives inputs, queues the expected post-edge outputs, then checks them.
// Latency: every expectation is checked 1 time unit after the rising edge that follows the drive.
// Backpressure: ready is driven per step to cover hold, release-without-transfer and transfer cases.
module tb_mux_arbiter8;
    localparam int N = 8;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HL = 1'b1;
`else
    localparam bit HL = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
        logic [7:0] f;
    } exp_t;

    logic clock;
    logic reset;
    logic [7:0] data [8];
    exp_t sb [$];
    int n_cmp;
    int n_err;

    mux_arbiter8_if #(.N(N)) u_if ();

    mux_arbiter8 #(.N(N), .MAX_HOLD(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic [7:0] rq, input logic rdy,
                        input logic [7:0] eg, input logic [2:0] es, input logic ev);
        exp_t e;
        exp_t got;
        reset      = rst;
        u_if.req   = rq;
        u_if.ready = rdy;
        for (int k = 0; k < 8; k++) data[k] = 8'($urandom);
        u_if.I00 = data[0]; u_if.I01 = data[1]; u_if.I02 = data[2]; u_if.I03 = data[3];
        u_if.I04 = data[4]; u_if.I05 = data[5]; u_if.I06 = data[6]; u_if.I07 = data[7];
        e.tag   = tag;
        e.grant = eg;
        e.sel   = es;
        e.valid = ev;
        e.f     = data[es];
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        check({got.tag, ".grant"}, u_if.grant, got.grant);
        check({got.tag, ".sel"},   {5'd0, u_if.sel}, {5'd0, got.sel});
        check({got.tag, ".valid"}, {7'd0, u_if.valid}, {7'd0, got.valid});
        check({got.tag, ".F"},     u_if.F, got.f);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        // Reset state.
        step("reset",      1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        // First request after reset: requester 0 wins one cycle later.
        step("first_gnt",  1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
        step("hold1",      1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
        step("hold2",      1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
        step("hold3",      1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
        // With the hold limit, the fourth transfer forces a release.
        step("hold4",      1'b0, 8'h01, 1'b1, HL ? 8'h00 : 8'h01, 3'd0, !HL);
        // Single requester: same requester owns again.
        step("hold5",      1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
        step("rel0",       1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
        // Owner 3 stalled by ready=0 for 5 cycles.
        step("gnt3",       1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1);
        for (int c = 0; c < 5; c++)
            step("stall3",  1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1);
        step("rel3",       1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0);
        // last=3, req 0 and 5: 5 is next in rotation.
        step("gnt5",       1'b0, 8'h21, 1'b0, 8'h20, 3'd5, 1'b1);
        step("rel5",       1'b0, 8'h00, 1'b0, 8'h00, 3'd5, 1'b0);
        // last=5, req 0 and 5: rotation wraps to 0.
        step("gnt0_l5",    1'b0, 8'h21, 1'b0, 8'h01, 3'd0, 1'b1);
        step("rel0b",      1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        // Reset during OWN with a transfer in the same cycle.
        step("gnt7",       1'b0, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1);
        step("rst_own",    1'b1, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0);
        step("gnt7_rst",   1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1);
        step("rel7",       1'b0, 8'h00, 1'b0, 8'h00, 3'd7, 1'b0);
        // last=7, req 0 and 5: requester 0 first.
        step("gnt0_l7",    1'b0, 8'h21, 1'b0, 8'h01, 3'd0, 1'b1);
        step("rel0c",      1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
        // Owner 2 drops request while stalled, then re-requests.
        step("gnt2",       1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1);
        step("drop2",      1'b0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0);
        step("regnt2",     1'b0, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1);
        // Release with another requester waiting: one IDLE cycle before the new grant.
        step("rel2_gap",   1'b0, 8'h08, 1'b1, 8'h00, 3'd2, 1'b0);
        step("gnt3b",      1'b0, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1);
        // Other requesters appearing do not preempt the owner.
        step("no_preempt", 1'b0, 8'hFF, 1'b1, 8'h08, 3'd3, 1'b1);
        step("rel3b",      1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
